// File: rtl/axis_rr_arbiter_if.sv
// AXI-Stream style bundle: valid/ready handshake carrying data, user, dest, tlast.
// master drives the payload and valid; slave returns ready.
interface axi_stream #(
   parameter int DATA_WIDTH = 32,
   parameter int USER_WIDTH = 32,
   parameter int DEST_WIDTH = 32
);
   logic                  valid;
   logic                  ready;
   logic [DATA_WIDTH-1:0] data;
   logic [USER_WIDTH-1:0] user;
   logic [DEST_WIDTH-1:0] dest;
   logic                  tlast;

   modport master (
      output valid, data, user, dest, tlast,
      input  ready
   );

   modport slave (
      input  valid, data, user, dest, tlast,
      output ready
   );
endinterface

// File: rtl/axis_rr_arbiter.sv
// Round-robin arbiter sharing one registered stream output among N_INPUTS
// streams without interleaving packets.
// Ports: clock, reset (sync, active-high), stream_in[N_INPUTS] (slaves),
// stream_out (master), grant_valid (grant held), grant_idx (current/last grantee).
module axis_rr_arbiter #(
   parameter int N_INPUTS    = 4,
   parameter int DATA_WIDTH  = 32,
   parameter int USER_WIDTH  = 32,
   parameter int DEST_WIDTH  = 32,
   parameter bit PACKET_MODE = 1'b1,
   parameter bit TAG_DEST    = 1'b0
) (
   input  logic                        clock,
   input  logic                        reset,
   axi_stream.slave                    stream_in [N_INPUTS],
   axi_stream.master                   stream_out,
   output logic                        grant_valid,
   output logic [$clog2(N_INPUTS)-1:0] grant_idx
);
   localparam int IW = $clog2(N_INPUTS);

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t state, state_next;

   logic [IW-1:0] ptr, ptr_next;
   logic [IW-1:0] gidx_next;
   logic          gv_next;

   logic [N_INPUTS-1:0]   in_valid;
   logic [N_INPUTS-1:0]   in_tlast;
   logic [N_INPUTS-1:0]   in_ready;
   logic [DATA_WIDTH-1:0] in_data [N_INPUTS];
   logic [USER_WIDTH-1:0] in_user [N_INPUTS];
   logic [DEST_WIDTH-1:0] in_dest [N_INPUTS];

   logic                  out_valid;
   logic [DATA_WIDTH-1:0] out_data;
   logic [USER_WIDTH-1:0] out_user;
   logic [DEST_WIDTH-1:0] out_dest;
   logic                  out_tlast;

   logic          out_free;
   logic          accept;
   logic          rel;
   logic          pick_found;
   logic [IW-1:0] pick_idx;
   logic [IW:0]   sum;
   logic [IW-1:0] cand;

   for (genvar i = 0; i < N_INPUTS; i++) begin : g_in
      assign in_valid[i]        = stream_in[i].valid;
      assign in_tlast[i]        = stream_in[i].tlast;
      assign in_data[i]         = stream_in[i].data;
      assign in_user[i]         = stream_in[i].user;
      assign in_dest[i]         = stream_in[i].dest;
      assign stream_in[i].ready = in_ready[i];
   end

   assign stream_out.valid = out_valid;
   assign stream_out.data  = out_data;
   assign stream_out.user  = out_user;
   assign stream_out.dest  = out_dest;
   assign stream_out.tlast = out_tlast;

   // Ready follows the output slot combinationally so a stalled output
   // blocks the grantee in the same cycle.
   assign out_free = !out_valid || stream_out.ready;

   always_comb begin
      in_ready = '0;
      for (int i = 0; i < N_INPUTS; i++) begin
         in_ready[i] = !reset && (state == LOCKED) &&
                       (grant_idx == IW'(i)) && out_free;
      end
   end

   assign accept = !reset && (state == LOCKED) &&
                   in_valid[grant_idx] && out_free;

   assign rel = accept && (!PACKET_MODE || in_tlast[grant_idx]);

   // Cyclic scan from ptr; the wrap is explicit so non-power-of-two
   // requester counts never see a phantom index.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      sum        = '0;
      cand       = '0;
      for (int k = 0; k < N_INPUTS; k++) begin
         sum = {1'b0, ptr} + (IW+1)'(k);
         if (sum >= (IW+1)'(N_INPUTS)) begin
            sum = sum - (IW+1)'(N_INPUTS);
         end
         cand = sum[IW-1:0];
         if (!pick_found && in_valid[cand]) begin
            pick_found = 1'b1;
            pick_idx   = cand;
         end
      end
   end

   always_comb begin
      state_next = state;
      ptr_next   = ptr;
      gidx_next  = grant_idx;
      gv_next    = grant_valid;
      unique case (state)
         IDLE: begin
            if (pick_found) begin
               gidx_next  = pick_idx;
               gv_next    = 1'b1;
               state_next = LOCKED;
            end
         end
         LOCKED: begin
            if (rel) begin
               ptr_next   = (grant_idx == IW'(N_INPUTS-1)) ?
                            '0 : grant_idx + 1'b1;
               gv_next    = 1'b0;
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= IDLE;
         ptr         <= '0;
         grant_idx   <= '0;
         grant_valid <= 1'b0;
      end else begin
         state       <= state_next;
         ptr         <= ptr_next;
         grant_idx   <= gidx_next;
         grant_valid <= gv_next;
      end
   end

   // Loading while draining keeps valid high for back-to-back beats.
   always_ff @(posedge clock) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_user  <= '0;
         out_dest  <= '0;
         out_tlast <= 1'b0;
      end else if (accept) begin
         out_valid <= 1'b1;
         out_data  <= in_data[grant_idx];
         out_user  <= in_user[grant_idx];
         out_dest  <= TAG_DEST ? DEST_WIDTH'(grant_idx) : in_dest[grant_idx];
         out_tlast <= in_tlast[grant_idx];
      end else if (stream_out.ready) begin
         out_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Directed bench for axis_rr_arbiter: reset, fairness, back-pressure,
// wrap/skip with three inputs, dest tagging, mid-packet reset, beat mode.
module tb_axis_rr_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;
   int beat [4];
   int plen   = 3;

   // A: 4 inputs, packet mode, dest passthrough
   logic [3:0]  a_valid, a_tlast, a_rdy;
   logic [15:0] a_data [4];
   logic [7:0]  a_user [4];
   logic [7:0]  a_dest [4];
   logic        a_gv;
   logic [1:0]  a_gi;
   axi_stream #(.DATA_WIDTH(16), .USER_WIDTH(8), .DEST_WIDTH(8)) a_in [4] ();
   axi_stream #(.DATA_WIDTH(16), .USER_WIDTH(8), .DEST_WIDTH(8)) a_out ();

   // B: 3 inputs, packet mode
   logic [2:0]  b_valid, b_tlast, b_rdy;
   logic [15:0] b_data [3];
   logic        b_gv;
   logic [1:0]  b_gi;
   axi_stream #(.DATA_WIDTH(16), .USER_WIDTH(8), .DEST_WIDTH(8)) b_in [3] ();
   axi_stream #(.DATA_WIDTH(16), .USER_WIDTH(8), .DEST_WIDTH(8)) b_out ();

   // C: 4 inputs, beat mode, dest tagging
   logic [3:0]  c_valid, c_rdy;
   logic [15:0] c_data [4];
   logic        c_gv;
   logic [1:0]  c_gi;
   axi_stream #(.DATA_WIDTH(16), .USER_WIDTH(8), .DEST_WIDTH(8)) c_in [4] ();
   axi_stream #(.DATA_WIDTH(16), .USER_WIDTH(8), .DEST_WIDTH(8)) c_out ();

   for (genvar i = 0; i < 4; i++) begin : g_a
      assign a_in[i].valid = a_valid[i];
      assign a_in[i].tlast = a_tlast[i];
      assign a_in[i].data  = a_data[i];
      assign a_in[i].user  = a_user[i];
      assign a_in[i].dest  = a_dest[i];
      assign a_rdy[i]      = a_in[i].ready;
      assign c_in[i].valid = c_valid[i];
      assign c_in[i].tlast = 1'b0;
      assign c_in[i].data  = c_data[i];
      assign c_in[i].user  = 8'h00;
      assign c_in[i].dest  = 8'hAA;
      assign c_rdy[i]      = c_in[i].ready;
   end

   for (genvar i = 0; i < 3; i++) begin : g_b
      assign b_in[i].valid = b_valid[i];
      assign b_in[i].tlast = b_tlast[i];
      assign b_in[i].data  = b_data[i];
      assign b_in[i].user  = 8'h00;
      assign b_in[i].dest  = 8'h00;
      assign b_rdy[i]      = b_in[i].ready;
   end

   axis_rr_arbiter #(
      .N_INPUTS(4), .DATA_WIDTH(16), .USER_WIDTH(8), .DEST_WIDTH(8),
      .PACKET_MODE(1'b1), .TAG_DEST(1'b0)
   ) dut_a (
      .clock(clk), .reset(rst), .stream_in(a_in), .stream_out(a_out),
      .grant_valid(a_gv), .grant_idx(a_gi)
   );

   axis_rr_arbiter #(
      .N_INPUTS(3), .DATA_WIDTH(16), .USER_WIDTH(8), .DEST_WIDTH(8),
      .PACKET_MODE(1'b1), .TAG_DEST(1'b0)
   ) dut_b (
      .clock(clk), .reset(rst), .stream_in(b_in), .stream_out(b_out),
      .grant_valid(b_gv), .grant_idx(b_gi)
   );

   axis_rr_arbiter #(
      .N_INPUTS(4), .DATA_WIDTH(16), .USER_WIDTH(8), .DEST_WIDTH(8),
      .PACKET_MODE(1'b0), .TAG_DEST(1'b1)
   ) dut_c (
      .clock(clk), .reset(rst), .stream_in(c_in), .stream_out(c_out),
      .grant_valid(c_gv), .grant_idx(c_gi)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] want);
      n_chk++;
      assert (got === want) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, want);
      end
   endtask

   // Source model for A: packet of plen beats, data = {idx, beat}.
   task automatic drive_src();
      for (int i = 0; i < 4; i++) begin
         a_data[i]  = 16'((i << 4) | beat[i]);
         a_tlast[i] = (beat[i] == plen - 1);
         a_user[i]  = 8'(i);
         a_dest[i]  = 8'hAA;
      end
   endtask

   task automatic step();
      logic [3:0] fire;
      #1;
      fire = a_valid & a_rdy;
      @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         if (fire[i]) beat[i] = (beat[i] == plen - 1) ? 0 : beat[i] + 1;
      end
      drive_src();
      #1;
   endtask

   initial begin
      a_valid = '0;
      b_valid = '0;
      c_valid = '0;
      b_tlast = 3'b111;
      for (int i = 0; i < 3; i++) b_data[i] = 16'(16'h50 + i);
      for (int i = 0; i < 4; i++) c_data[i] = 16'(16'h30 + i);
      for (int i = 0; i < 4; i++) beat[i] = 0;
      a_out.ready = 1'b1;
      b_out.ready = 1'b1;
      c_out.ready = 1'b1;
      drive_src();
      a_valid = 4'hF;

      // reset with all inputs requesting
      repeat (3) begin
         @(negedge clk);
         #1;
         chk("rst_valid", a_out.valid, 0);
         chk("rst_data", a_out.data, 0);
         chk("rst_user", a_out.user, 0);
         chk("rst_dest", a_out.dest, 0);
         chk("rst_tlast", a_out.tlast, 0);
         chk("rst_gv", a_gv, 0);
         chk("rst_gi", a_gi, 0);
         chk("rst_ready", a_rdy, 0);
      end
      rst = 1'b0;
      step();

      // fairness: 3-beat packets from all four, 4 cycles each
      for (int c = 0; c < 20; c++) begin
         int pkt;
         int ph;
         pkt = c / 4;
         ph  = c % 4;
         chk($sformatf("fair_valid c%0d", c), a_out.valid, ph != 0);
         chk($sformatf("fair_gv c%0d", c), a_gv, ph != 3);
         if (ph == 0) begin
            chk($sformatf("fair_gi c%0d", c), a_gi, pkt % 4);
         end else begin
            chk($sformatf("fair_data c%0d", c), a_out.data,
                ((pkt % 4) << 4) | (ph - 1));
            chk($sformatf("fair_tlast c%0d", c), a_out.tlast, ph == 3);
            chk($sformatf("fair_user c%0d", c), a_out.user, pkt % 4);
            chk($sformatf("fair_dest c%0d", c), a_out.dest, 8'hAA);
         end
         if (c == 19) a_valid = '0;
         step();
      end

      // back-pressure on input 2 (ptr is 1)
      a_valid[2] = 1'b1;
      step();
      chk("bp_gv", a_gv, 1);
      chk("bp_gi", a_gi, 2);
      chk("bp_v0", a_out.valid, 0);
      chk("bp_rdy0", a_rdy[2], 1);
      step();
      chk("bp_d0", a_out.data, 16'h20);
      chk("bp_t0", a_out.tlast, 0);
      step();
      chk("bp_d1", a_out.data, 16'h21);
      a_out.ready = 1'b0;
      #1;
      chk("bp_stall_rdy1", a_rdy[2], 0);
      step();
      chk("bp_hold_v", a_out.valid, 1);
      chk("bp_hold_d", a_out.data, 16'h21);
      chk("bp_stall_rdy2", a_rdy[2], 0);
      step();
      chk("bp_hold_d2", a_out.data, 16'h21);
      a_out.ready = 1'b1;
      #1;
      chk("bp_rdy_back", a_rdy[2], 1);
      step();
      chk("bp_d2", a_out.data, 16'h22);
      chk("bp_t2", a_out.tlast, 1);
      chk("bp_rel", a_gv, 0);
      a_valid[2] = 1'b0;
      step();
      chk("bp_drain", a_out.valid, 0);

      // reset in the middle of a 5-beat packet from input 1 (ptr is 3)
      plen = 5;
      drive_src();
      a_valid[1] = 1'b1;
      step();
      chk("mr_gi", a_gi, 1);
      step();
      chk("mr_d0", a_out.data, 16'h10);
      step();
      chk("mr_d1", a_out.data, 16'h11);
      chk("mr_t1", a_out.tlast, 0);
      rst = 1'b1;
      step();
      chk("mr_valid", a_out.valid, 0);
      chk("mr_gv", a_gv, 0);
      chk("mr_gi_rst", a_gi, 0);
      chk("mr_ready", a_rdy, 0);
      rst = 1'b0;
      beat[1] = 0;
      plen = 3;
      a_valid = 4'b1001;
      drive_src();
      step();
      chk("mr_regrant_gv", a_gv, 1);
      chk("mr_regrant_gi", a_gi, 0);
      a_valid = '0;
      step();

      // wrap and skip with three inputs
      b_valid[1] = 1'b1;
      step();
      chk("w_gv1", b_gv, 1);
      chk("w_gi1", b_gi, 1);
      step();
      chk("w_out1", b_out.data, 16'h51);
      chk("w_rel1", b_gv, 0);
      b_valid[0] = 1'b1;
      step();
      chk("w_gi0", b_gi, 0);
      chk("w_gv0", b_gv, 1);
      step();
      chk("w_out0", b_out.data, 16'h50);
      chk("w_last0", b_out.tlast, 1);
      b_valid[0] = 1'b0;
      step();
      chk("w_gi1b", b_gi, 1);
      chk("w_gv1b", b_gv, 1);
      step();
      chk("w_out1b", b_out.data, 16'h51);
      chk("w_v1b", b_out.valid, 1);
      b_valid = '0;
      step();

      // tagging: input 3 with dest 0xAA comes out with dest 3
      c_valid[3] = 1'b1;
      step();
      chk("tag_gi", c_gi, 3);
      chk("tag_gv", c_gv, 1);
      step();
      chk("tag_valid", c_out.valid, 1);
      chk("tag_dest", c_out.dest, 3);
      chk("tag_data", c_out.data, 16'h33);
      chk("tag_rel", c_gv, 0);
      c_valid = 4'b0011;
      step();

      // beat mode: 0,1,0,1 at one beat per two cycles
      for (int d = 0; d < 8; d++) begin
         if (d % 2 == 0) begin
            chk($sformatf("bm_bubble d%0d", d), c_out.valid, 0);
            chk($sformatf("bm_gv d%0d", d), c_gv, 1);
            chk($sformatf("bm_gi d%0d", d), c_gi, (d / 2) % 2);
         end else begin
            chk($sformatf("bm_valid d%0d", d), c_out.valid, 1);
            chk($sformatf("bm_data d%0d", d), c_out.data,
                16'h30 + (d / 2) % 2);
            chk($sformatf("bm_dest d%0d", d), c_out.dest, (d / 2) % 2);
         end
         step();
      end
      c_valid = '0;
      step();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule
